mem_arbiter_ctrl: RTL and testbench

//  Shares the single byte-wide RAM port between instruction fetch (IF) and load/store (MEM).

---
 rtl/mem_arbiter_ctrl.sv | 160 ++++++++++++++++
 tb/tb_mem_arbiter_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_ctrl.sv
// Purpose: arbitrates one byte-wide RAM port between instruction fetch and load/store, serialising transfers into byte accesses.
// Latency: after the request is latched, a read of N bytes completes in cycle N+1 (last byte bypassed from ram_din); a write completes in cycle N.
// Backpressure: requesters hold req until done; stall_state freezes the pipeline meanwhile; no preemption, MEM wins ties in IDLE.
module mem_arbiter_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int STALL_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_req,
    input  logic [ADDR_W-1:0]  if_addr,
    output logic [31:0]        if_inst,
    output logic               if_done,
    input  logic               ex_be_i,
    input  logic               mem_req,
    input  logic               mem_we,
    input  logic [1:0]         mem_size,
    input  logic [ADDR_W-1:0]  mem_addr,
    input  logic [31:0]        mem_wdata,
    output logic [31:0]        mem_rdata,
    output logic               mem_done,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic               ram_wr,
    output logic [7:0]         ram_dout,
    input  logic [7:0]         ram_din,
    output logic [STALL_W-1:0] stall_state
);

    typedef enum logic [1:0] {IDLE, IF_RD, MEM_RD, MEM_WR} state_t;

    state_t              state_q;
    logic [2:0]          cyc_q;      // cycles since the request was latched (0 in IDLE)
    logic [2:0]          n_q;        // byte count of the current transfer
    logic [31:0]         buf_q;      // read bytes collected so far
    logic [31:0]         if_inst_q;
    logic [31:0]         mem_rdata_q;
    logic                if_done_q;
    logic                mem_done_q;
    logic [ADDR_W-1:0]   ram_addr_q;
    logic                ram_wr_q;
    logic [7:0]          ram_dout_q;
    logic [1:0]          lane_idx;
    logic [31:0]         rd_data_d;
    logic [2:0]          mem_n;

    function automatic logic [2:0] size_to_n(input logic [1:0] size);
        case (size)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    assign mem_n = size_to_n(mem_size);

    // Byte lane being returned this cycle; RAM data lags its address by one cycle.
    // In the done cycle the final byte is still on ram_din, so it is merged here rather than waited for.
    always_comb begin
        lane_idx  = 2'(cyc_q - 3'd2);
        rd_data_d = buf_q;
        rd_data_d[{lane_idx, 3'b000} +: 8] = ram_din;
    end

    // Transfer FSM with registered RAM-side outputs and done pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cyc_q       <= 3'd0;
            n_q         <= 3'd0;
            buf_q       <= 32'd0;
            if_inst_q   <= 32'd0;
            mem_rdata_q <= 32'd0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            ram_addr_q  <= '0;
            ram_wr_q    <= 1'b0;
            ram_dout_q  <= 8'd0;
        end else begin
            if_done_q  <= 1'b0;
            mem_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mem_req) begin
                        n_q        <= mem_n;
                        cyc_q      <= 3'd1;
                        ram_addr_q <= mem_addr;
                        buf_q      <= 32'd0;
                        if (mem_we) begin
                            state_q    <= MEM_WR;
                            ram_wr_q   <= 1'b1;
                            ram_dout_q <= mem_wdata[7:0];
                            mem_done_q <= (mem_n == 3'd1);
                        end else begin
                            state_q <= MEM_RD;
                        end
                    end else if (if_req && !ex_be_i) begin
                        state_q    <= IF_RD;
                        n_q        <= 3'd4;
                        cyc_q      <= 3'd1;
                        ram_addr_q <= if_addr;
                        buf_q      <= 32'd0;
                    end
                end
                IF_RD, MEM_RD: begin
                    if (state_q == IF_RD && ex_be_i) begin
                        // Flush: drop the fetch so IF/ID never receives a stale instruction.
                        state_q <= IDLE;
                        cyc_q   <= 3'd0;
                    end else if (cyc_q == n_q + 3'd1) begin
                        state_q <= IDLE;
                        cyc_q   <= 3'd0;
                        if (state_q == IF_RD) if_inst_q   <= rd_data_d;
                        else                  mem_rdata_q <= rd_data_d;
                    end else begin
                        cyc_q <= cyc_q + 3'd1;
                        if (cyc_q >= 3'd2) buf_q[{lane_idx, 3'b000} +: 8] <= ram_din;
                        if (cyc_q < n_q)   ram_addr_q <= ram_addr_q + ADDR_W'(1);
                        if (cyc_q == n_q) begin
                            if (state_q == IF_RD) if_done_q  <= 1'b1;
                            else                  mem_done_q <= 1'b1;
                        end
                    end
                end
                MEM_WR: begin
                    if (cyc_q == n_q) begin
                        state_q  <= IDLE;
                        cyc_q    <= 3'd0;
                        ram_wr_q <= 1'b0;
                    end else begin
                        cyc_q      <= cyc_q + 3'd1;
                        ram_addr_q <= ram_addr_q + ADDR_W'(1);
                        ram_dout_q <= mem_wdata[{cyc_q[1:0], 3'b000} +: 8];
                        mem_done_q <= (cyc_q + 3'd1 == n_q);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cyc_q   <= 3'd0;
                end
            endcase
        end
    end

    // Read data is live in its done cycle and held by the capture registers afterwards.
    // A write is suppressed while reset is asserted so an abandoned store stops immediately.
    always_comb begin
        if_inst   = if_done_q ? rd_data_d : if_inst_q;
        mem_rdata = (mem_done_q && state_q == MEM_RD) ? rd_data_d : mem_rdata_q;
        if_done   = if_done_q;
        mem_done  = mem_done_q;
        ram_addr  = ram_addr_q;
        ram_wr    = ram_wr_q & ~rst;
        ram_dout  = ram_dout_q;
        if (rst)                        stall_state = '0;
        else if (mem_req && !mem_done_q) stall_state = STALL_W'(6'b011111);
        else if (if_req && !if_done_q)   stall_state = STALL_W'(6'b000011);
        else                            stall_state = '0;
    end

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Self-checking bench for mem_arbiter_ctrl: byte RAM model, reference memory image and transaction-level timing rules.
// Latency: reads complete N+1 cycles after the request cycle, writes N cycles.
// Backpressure: requests are held until their done pulse; stall_state is checked every cycle of each transfer.
module tb_mem_arbiter_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_inst;
    logic        if_done;
    logic        ex_be_i;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic [31:0] ram_addr;
    logic        ram_wr;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din;
    logic [5:0]  stall_state;

    int checks = 0;
    int errors = 0;

    logic [7:0] ram    [0:65535];  // the RAM the DUT talks to
    logic [7:0] ref_mm [0:65535];  // expected memory image

    always #5 clk = ~clk;

    mem_arbiter_ctrl #(.ADDR_W(32), .STALL_W(6)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_inst(if_inst), .if_done(if_done),
        .ex_be_i(ex_be_i),
        .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
        .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din),
        .stall_state(stall_state)
    );

    // Synchronous byte RAM: read data appears one cycle after the address.
    always @(posedge clk) begin
        if (ram_wr) ram[ram_addr[15:0]] <= ram_dout;
        ram_din <= ram[ram_addr[15:0]];
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] addr, input int n);
        logic [31:0] v = 32'd0;
        for (int k = 0; k < n; k++) v = v | (32'(ref_mm[16'(addr + 32'(k))]) << (8 * k));
        return v;
    endfunction

    task automatic poke(input logic [31:0] addr, input logic [7:0] v);
        ram[addr[15:0]]    = v;
        ref_mm[addr[15:0]] = v;
    endtask

    // Drives one load/store; reports done latency (-1 on timeout), read data and whether side signals stayed legal.
    task automatic mem_xfer(input logic we, input logic [1:0] size, input logic [31:0] addr,
                            input logic [31:0] wdata, output int lat, output logic [31:0] rd,
                            output bit side_ok);
        mem_req = 1'b1; mem_we = we; mem_size = size; mem_addr = addr; mem_wdata = wdata;
        lat = -1; rd = 32'd0; side_ok = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (mem_done) begin
                lat = c; rd = mem_rdata;
                if (stall_state !== 6'b000000) side_ok = 1'b0;
                break;
            end
            if (stall_state !== 6'b011111) side_ok = 1'b0;
            if (!we && ram_wr !== 1'b0) side_ok = 1'b0;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        mem_req = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] addr, output int lat, output logic [31:0] rd,
                         output bit side_ok);
        if_req = 1'b1; if_addr = addr;
        lat = -1; rd = 32'd0; side_ok = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ram_wr !== 1'b0) side_ok = 1'b0;
            if (if_done) begin
                lat = c; rd = if_inst;
                if (stall_state !== 6'b000000) side_ok = 1'b0;
                break;
            end
            if (stall_state !== 6'b000011) side_ok = 1'b0;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        if_req = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({if_done, mem_done, ram_wr, ram_dout, ram_addr, stall_state, if_inst, mem_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got if_done=%b mem_done=%b ram_wr=%b ram_dout=%h ram_addr=%h stall=%b if_inst=%h mem_rdata=%h, want all zero",
                     if_done, mem_done, ram_wr, ram_dout, ram_addr, stall_state, if_inst, mem_rdata);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_fetch;
        int lat; logic [31:0] rd; bit ok;
        poke(32'h100, 8'h13); poke(32'h101, 8'h05); poke(32'h102, 8'hA0); poke(32'h103, 8'h00);
        fetch(32'h100, lat, rd, ok);
        checks++;
        if (lat !== 5) begin errors++; $display("FAIL fetch_latency: got %0d want 5", lat); end
        checks++;
        if (rd !== 32'h00A00513) begin errors++; $display("FAIL fetch_data: got %h want 00a00513", rd); end
        checks++;
        if (!ok) begin errors++; $display("FAIL fetch_stall: stall/ram_wr wrong during fetch, want 000011 and ram_wr=0"); end
        @(negedge clk);
        checks++;
        if (if_inst !== 32'h00A00513) begin errors++; $display("FAIL fetch_hold: got %h want 00a00513", if_inst); end
        @(posedge clk); #1;
    endtask

    task automatic test_load_byte;
        int lat; logic [31:0] rd; bit ok;
        poke(32'h2003, 8'hFF);
        mem_xfer(1'b0, 2'd0, 32'h2003, 32'h0, lat, rd, ok);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL load_byte_latency: got %0d want 2", lat); end
        checks++;
        if (rd !== 32'h000000FF) begin errors++; $display("FAIL load_byte_data: got %h want 000000ff", rd); end
        checks++;
        if (!ok) begin errors++; $display("FAIL load_byte_stall: stall/ram_wr wrong during load"); end
    endtask

    task automatic test_store_half;
        int lat; logic [31:0] rd; bit ok;
        poke(32'h40, 8'h00); poke(32'h41, 8'h00); poke(32'h42, 8'h5A);
        mem_xfer(1'b1, 2'd1, 32'h40, 32'hDEADBEEF, lat, rd, ok);
        ref_mm[16'h40] = 8'hEF; ref_mm[16'h41] = 8'hBE;
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL store_half_latency: got %0d want 2", lat); end
        checks++;
        if ({ram[16'h40], ram[16'h41], ram[16'h42]} !== {ref_mm[16'h40], ref_mm[16'h41], ref_mm[16'h42]})
        begin
            errors++;
            $display("FAIL store_half_ram: got %h %h %h want ef be 5a", ram[16'h40], ram[16'h41], ram[16'h42]);
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL store_half_stall: stall wrong during store"); end
    endtask

    task automatic test_priority;
        int mem_lat = -1, if_lat = -1;
        logic [31:0] mrd = 0, ird = 0;
        bit stall_bad = 0;
        for (int k = 0; k < 4; k++) begin
            poke(32'h600 + 32'(k), 8'(8'h11 * (k + 1)));
            poke(32'h700 + 32'(k), 8'(8'hA1 + k));
        end
        mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd2; mem_addr = 32'h600;
        if_req = 1'b1; if_addr = 32'h700;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (mem_lat < 0) begin
                if (mem_done) begin mem_lat = c; mrd = mem_rdata; end
                else if (stall_state !== 6'b011111) stall_bad = 1;
            end
            if (if_done && if_lat < 0) begin if_lat = c; ird = if_inst; end
            else if (mem_lat >= 0 && if_lat < 0 && stall_state !== 6'b000011) stall_bad = 1;
            @(posedge clk); #1;
            if (mem_lat == c) mem_req = 1'b0;
            if (if_lat == c) begin if_req = 1'b0; break; end
        end
        if_req = 1'b0; mem_req = 1'b0;
        checks++;
        if (mem_lat !== 5) begin errors++; $display("FAIL prio_mem_latency: got %0d want 5", mem_lat); end
        checks++;
        if (mrd !== ref_read(32'h600, 4)) begin errors++; $display("FAIL prio_mem_data: got %h want %h", mrd, ref_read(32'h600, 4)); end
        checks++;
        if (if_lat !== 11) begin errors++; $display("FAIL prio_fetch_latency: got %0d want 11", if_lat); end
        checks++;
        if (ird !== ref_read(32'h700, 4)) begin errors++; $display("FAIL prio_fetch_data: got %h want %h", ird, ref_read(32'h700, 4)); end
        checks++;
        if (stall_bad) begin errors++; $display("FAIL prio_stall: stall_state wrong while arbitrating, want 011111 then 000011"); end
    endtask

    task automatic test_flush;
        int lat = -1;
        logic [31:0] rd = 0;
        bit wr_bad = 0;
        logic [31:0] idle_addr = 0;
        poke(32'h200, 8'h93); poke(32'h201, 8'h00); poke(32'h202, 8'h10); poke(32'h203, 8'h00);
        for (int k = 0; k < 4; k++) poke(32'h300 + 32'(k), 8'hC0 + 8'(k));
        if_req = 1'b1; if_addr = 32'h300;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ram_wr !== 1'b0) wr_bad = 1;
            if (c == 4) idle_addr = ram_addr;
            if (if_done && lat < 0) begin lat = c; rd = if_inst; end
            @(posedge clk); #1;
            if (c == 2) ex_be_i = 1'b1;
            if (c == 3) begin ex_be_i = 1'b0; if_addr = 32'h200; end
            if (lat == c) begin if_req = 1'b0; break; end
        end
        if_req = 1'b0; ex_be_i = 1'b0;
        checks++;
        if (lat !== 9) begin errors++; $display("FAIL flush_refetch_latency: got %0d want 9 (no done before)", lat); end
        checks++;
        if (rd !== 32'h00100093) begin errors++; $display("FAIL flush_refetch_data: got %h want 00100093", rd); end
        checks++;
        if (idle_addr !== 32'h302) begin errors++; $display("FAIL flush_idle_addr: got %h want 00000302", idle_addr); end
        checks++;
        if (wr_bad) begin errors++; $display("FAIL flush_ram_wr: ram_wr asserted during fetch/flush, want 0"); end
    endtask

    task automatic test_reset_mid_store;
        bit done_seen = 0;
        logic [31:0] snap = 32'hFFFF_FFFF;
        logic [5:0]  snap_stall = 6'h3F;
        logic [7:0]  snap_misc = 8'hFF;
        for (int k = 0; k < 4; k++) poke(32'h500 + 32'(k), 8'h00);
        mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd2; mem_addr = 32'h500; mem_wdata = 32'h11223344;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (mem_done) done_seen = 1;
            if (c == 3) begin
                snap = ram_addr | if_inst | mem_rdata;
                snap_stall = stall_state;
                snap_misc = {5'd0, ram_wr, if_done, mem_done} | ram_dout;
            end
            @(posedge clk); #1;
            if (c == 1) begin rst = 1'b1; mem_req = 1'b0; end
            if (c == 2) rst = 1'b0;
        end
        ref_mm[16'h500] = 8'h44;
        checks++;
        if ({snap, snap_stall, snap_misc} !== '0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got addr|data=%h stall=%b misc=%h want all zero", snap, snap_stall, snap_misc);
        end
        checks++;
        if ({ram[16'h500], ram[16'h501], ram[16'h502], ram[16'h503]} !==
            {ref_mm[16'h500], ref_mm[16'h501], ref_mm[16'h502], ref_mm[16'h503]}) begin
            errors++;
            $display("FAIL rst_mid_ram: got %h %h %h %h want 44 00 00 00",
                     ram[16'h500], ram[16'h501], ram[16'h502], ram[16'h503]);
        end
        checks++;
        if (done_seen) begin errors++; $display("FAIL rst_mid_done: got mem_done pulse, want none"); end
    endtask

    task automatic test_random;
        int lat, n, kind;
        logic [31:0] rd, addr, wdata, exp;
        logic [1:0] size;
        bit ok, ram_bad;
        for (int i = 0; i < 40; i++) begin
            kind = int'($urandom_range(0, 2));
            if (kind == 0) begin
                addr = 32'h1000 + (32'($urandom_range(0, 32'h3FC)) & ~32'h3);
                exp = ref_read(addr, 4);
                fetch(addr, lat, rd, ok);
                checks++;
                if (lat !== 5 || rd !== exp || !ok) begin
                    errors++;
                    $display("FAIL rand_fetch[%0d]: addr=%h got lat=%0d data=%h ok=%0d want lat=5 data=%h ok=1",
                             i, addr, lat, rd, ok, exp);
                end
            end else begin
                size = 2'($urandom_range(0, 3));
                n = nbytes(size);
                addr = 32'h1000 + 32'($urandom_range(0, 32'hFF0));
                wdata = $urandom;
                if (kind == 1) begin
                    exp = ref_read(addr, n);
                    mem_xfer(1'b0, size, addr, 32'h0, lat, rd, ok);
                    checks++;
                    if (lat !== n + 1 || rd !== exp || !ok) begin
                        errors++;
                        $display("FAIL rand_load[%0d]: addr=%h size=%0d got lat=%0d data=%h ok=%0d want lat=%0d data=%h ok=1",
                                 i, addr, size, lat, rd, ok, n + 1, exp);
                    end
                end else begin
                    mem_xfer(1'b1, size, addr, wdata, lat, rd, ok);
                    for (int k = 0; k < n; k++) ref_mm[16'(addr + 32'(k))] = wdata[8*k +: 8];
                    ram_bad = 0;
                    for (int k = 0; k <= n; k++)
                        if (ram[16'(addr + 32'(k))] !== ref_mm[16'(addr + 32'(k))]) ram_bad = 1;
                    checks++;
                    if (lat !== n || ram_bad || !ok) begin
                        errors++;
                        $display("FAIL rand_store[%0d]: addr=%h size=%0d got lat=%0d ram_bad=%0d ok=%0d want lat=%0d ram_bad=0 ok=1",
                                 i, addr, size, lat, ram_bad, ok, n);
                    end
                end
            end
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
    endtask

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = 32'h0; ex_be_i = 1'b0;
        mem_req = 1'b0; mem_we = 1'b0; mem_size = 2'd0; mem_addr = 32'h0; mem_wdata = 32'h0;
        for (int a = 0; a < 65536; a++) begin
            ram[a]    = 8'($urandom);
            ref_mm[a] = ram[a];
        end
        test_reset();
        test_fetch();
        test_load_byte();
        test_store_half();
        test_priority();
        test_flush();
        test_reset_mid_store();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
